lift_shaft_model: RTL and testbench

//  Behavioural-synthesisable model of the lift car and shaft, downstream of the lift controller.

---
 rtl/lift_pkg.sv | 24 ++
 rtl/lift_step_timer.sv | 46 ++++
 rtl/lift_shaft_model.sv | 133 +++++++++++++
 tb/tb_lift_shaft_model.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// -----------------------------------------------------------------------------
// lift_pkg
// Shared encodings for the lift shaft model: motor command levels, sensor
// polarity, fault bit positions and the packed floor-sensor bundle.
// No ports (package).
// -----------------------------------------------------------------------------
package lift_pkg;

    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;
    localparam logic MOTOR_RUN   = 1'b0;   // enable level that lets the motor turn
    localparam logic SENS_ACTIVE = 1'b0;   // floor sensors pull low when the car is in range

    localparam int FLT_OVERRUN   = 0;      // tick taken while already at the commanded limit
    localparam int FLT_REVERSAL  = 1;      // direction flipped part-way through a step period

    typedef struct packed {
        logic top;
        logic middle_plus;
        logic middle_minus;
        logic bottom;
    } sens_t;

endpackage

// File: rtl/lift_step_timer.sv
// -----------------------------------------------------------------------------
// lift_step_timer
// Step prescaler for the lift motor. Counts 0..STEP_DIV-1 while the motor runs
// and is held at 0 while stopped, so every restart begins a full step period.
// Ports:
//   clock     in  system clock
//   n_reset   in  asynchronous active-low reset
//   run       in  1 = motor running (count), 0 = stopped (hold at 0)
//   tick      out one-cycle pulse when the count reaches STEP_DIV-1
//   mid_phase out count is non-zero (a step period is in progress)
// -----------------------------------------------------------------------------
module lift_step_timer #(
    parameter int STEP_DIV = 50000
) (
    input  logic clock,
    input  logic n_reset,
    input  logic run,
    output logic tick,
    output logic mid_phase
);

    localparam int            CW   = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick      = run && (cnt_q == LAST);
    assign mid_phase = (cnt_q != '0);

endmodule

// File: rtl/lift_shaft_model.sv
// -----------------------------------------------------------------------------
// lift_shaft_model
// Synthesisable stand-in for the lift car and shaft. Integrates the motor
// commands into a saturating car position, feeds the four active-low floor
// sensors back to the controller and flags shaft faults for debug display.
// Ports:
//   clock         in   system clock
//   n_reset       in   asynchronous active-low reset
//   direction     in   1 = up, 0 = down
//   enable        in   active-low motor run (0 = move, 1 = stop)
//   top           out  active-low: car at top floor
//   middle_plus   out  active-low: car in upper half of middle window
//   middle_minus  out  active-low: car in lower half of middle window
//   bottom        out  active-low: car at bottom floor
//   position      out  current car position (zero-extended to 16 bits)
//   moving        out  motor enabled and not pressed against the commanded limit
//   fault         out  sticky: [0] limit overrun, [1] reversal while moving
// -----------------------------------------------------------------------------
module lift_shaft_model
    import lift_pkg::*;
#(
    parameter int STEP_DIV  = 50000,
    parameter int POS_MAX   = 400,
    parameter int POS_MID   = 200,
    parameter int SENS_W    = 10,
    parameter int RESET_POS = 200
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic        direction,
    input  logic        enable,
    output logic        top,
    output logic        middle_plus,
    output logic        middle_minus,
    output logic        bottom,
    output logic [15:0] position,
    output logic        moving,
    output logic [1:0]  fault
);

    localparam logic [15:0] POS_MAX_V = 16'(POS_MAX);
    localparam logic [15:0] RESET_V   = 16'(RESET_POS);
    localparam logic [15:0] BOT_HI    = 16'(SENS_W);
    localparam logic [15:0] TOP_LO    = 16'(POS_MAX - SENS_W);
    localparam logic [15:0] MID_LO    = 16'(POS_MID - SENS_W);
    localparam logic [15:0] MID_V     = 16'(POS_MID);
    localparam logic [15:0] MID_HI    = 16'(POS_MID + SENS_W);

    function automatic logic sens_level(input logic in_range);
        return in_range ? SENS_ACTIVE : ~SENS_ACTIVE;
    endfunction

    function automatic sens_t decode(input logic [15:0] p);
        sens_t s;
        s.bottom       = sens_level(p <= BOT_HI);
        s.top          = sens_level(p >= TOP_LO);
        s.middle_minus = sens_level((p >= MID_LO) && (p <= MID_V));
        s.middle_plus  = sens_level((p >= MID_V) && (p <= MID_HI));
        return s;
    endfunction

    logic [15:0] pos_q,   pos_d;
    logic [1:0]  fault_q, fault_d;
    logic        dir_q;
    sens_t       sens_q,  sens_d;
    logic        active_q;          // low during reset so moving reads 0 there

    logic run;
    logic tick;
    logic mid_phase;
    logic at_cmd_limit;

    assign run = (enable == MOTOR_RUN);

    lift_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .clock     (clock),
        .n_reset   (n_reset),
        .run       (run),
        .tick      (tick),
        .mid_phase (mid_phase)
    );

    assign at_cmd_limit = (direction == DIR_UP) ? (pos_q == POS_MAX_V) : (pos_q == '0);

    always_comb begin
        pos_d   = pos_q;
        fault_d = fault_q;
        sens_d  = decode(pos_q);

        // Flipping direction with a step half-accumulated would jerk a real motor.
        if (run && mid_phase && (direction != dir_q)) begin
            fault_d[FLT_REVERSAL] = 1'b1;
        end

        // The step always follows the live direction, even on a reversal cycle.
        if (tick) begin
            if (at_cmd_limit) begin
                fault_d[FLT_OVERRUN] = 1'b1;
            end else if (direction == DIR_UP) begin
                pos_d = pos_q + 16'd1;
            end else begin
                pos_d = pos_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            pos_q    <= RESET_V;
            fault_q  <= 2'b00;
            dir_q    <= DIR_UP;
            sens_q   <= decode(RESET_V);
            active_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            fault_q  <= fault_d;
            dir_q    <= direction;
            sens_q   <= sens_d;
            active_q <= 1'b1;
        end
    end

    assign position     = pos_q;
    assign fault        = fault_q;
    assign moving       = active_q && run && !at_cmd_limit;
    assign top          = sens_q.top;
    assign middle_plus  = sens_q.middle_plus;
    assign middle_minus = sens_q.middle_minus;
    assign bottom       = sens_q.bottom;

endmodule

// File: tb/tb_lift_shaft_model.sv
// -----------------------------------------------------------------------------
// tb_lift_shaft_model
// Directed scoreboard bench for lift_shaft_model with a short step period.
// Stimulus queues hand-computed expectations tagged with the cycle they apply
// to; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_lift_shaft_model;

    localparam int K_POS  = 0;
    localparam int K_SENS = 1;   // {top, middle_plus, middle_minus, bottom}
    localparam int K_FLT  = 2;
    localparam int K_MOV  = 3;

    typedef struct {
        int          due;
        string       name;
        int          kind;
        logic [15:0] val;
    } sb_item_t;

    logic        clock = 1'b0;
    logic        n_reset;
    logic        direction;
    logic        enable;
    logic        top, middle_plus, middle_minus, bottom;
    logic [15:0] position;
    logic        moving;
    logic [1:0]  fault;

    int       cyc   = 0;
    int       total = 0;
    int       bad   = 0;
    sb_item_t sb[$];
    sb_item_t it;
    logic [15:0] act;

    lift_shaft_model #(
        .STEP_DIV  (4),
        .POS_MAX   (40),
        .POS_MID   (20),
        .SENS_W    (2),
        .RESET_POS (20)
    ) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .direction    (direction),
        .enable       (enable),
        .top          (top),
        .middle_plus  (middle_plus),
        .middle_minus (middle_minus),
        .bottom       (bottom),
        .position     (position),
        .moving       (moving),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            case (it.kind)
                K_POS:   act = position;
                K_SENS:  act = {12'd0, top, middle_plus, middle_minus, bottom};
                K_FLT:   act = {14'd0, fault};
                default: act = {15'd0, moving};
            endcase
            total++;
            if (act !== it.val) begin
                bad++;
                $display("FAIL %s @cyc %0d: got %0h expected %0h", it.name, cyc, act, it.val);
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input string nm, input int kind, input logic [15:0] v);
        sb_item_t e;
        e.due  = cyc;
        e.name = nm;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Sensor words after each of the four up-steps from 20: 21, 22, 23, 24.
    logic [3:0] up_sens [1:4] = '{4'b1011, 4'b1011, 4'b1111, 4'b1111};

    initial begin
        bit done;

        // 1: reset state
        n_reset   = 1'b0;
        enable    = 1'b1;
        direction = 1'b1;
        tick_n(2);
        expect_v("rst_pos",  K_POS,  16'd20);
        expect_v("rst_sens", K_SENS, 16'b1001);
        expect_v("rst_flt",  K_FLT,  16'd0);
        expect_v("rst_mov",  K_MOV,  16'd0);
        tick_n(1);

        // 2: run up four steps
        n_reset   = 1'b1;
        enable    = 1'b0;
        direction = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick_n(1);
            if (i % 4 == 0) begin
                expect_v("up_pos", K_POS, 16'(20 + i / 4));
                expect_v("up_sens_lag", K_SENS, (i == 4) ? 16'b1001 : 16'(up_sens[i / 4 - 1]));
            end
            if (i % 4 == 1 && i > 1) begin
                expect_v("up_sens", K_SENS, 16'(up_sens[(i - 1) / 4]));
            end
        end
        expect_v("up_mov", K_MOV, 16'd1);

        // 3: stop mid-period, legal direction change while stopped
        tick_n(2);
        expect_v("up_sens24", K_SENS, 16'b1111);
        enable    = 1'b1;
        direction = 1'b0;
        #1;
        expect_v("stop_mov", K_MOV, 16'd0);
        tick_n(20);
        expect_v("stop_pos", K_POS, 16'd24);
        expect_v("stop_flt", K_FLT, 16'd0);

        // 4: down to bottom, then one tick into the floor
        enable = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick_n(1);
            if (i == 3)   expect_v("restart_hold", K_POS,  16'd24);
            if (i == 4)   expect_v("restart_step", K_POS,  16'd23);
            if (i == 88)  expect_v("dn_pos2",      K_POS,  16'd2);
            if (i == 88)  expect_v("dn_sens_lag",  K_SENS, 16'b1111);
            if (i == 89)  expect_v("dn_bottom",    K_SENS, 16'b1110);
            if (i == 96)  expect_v("dn_pos0",      K_POS,  16'd0);
            if (i == 96)  expect_v("dn_mov_lim",   K_MOV,  16'd0);
            if (i == 99)  expect_v("dn_flt_pre",   K_FLT,  16'd0);
            if (i == 100) expect_v("ovr_pos",      K_POS,  16'd0);
            if (i == 100) expect_v("ovr_flt",      K_FLT,  16'd1);
        end

        // 5: head up, then reverse mid-period
        direction = 1'b1;
        #1;
        expect_v("rev_mov", K_MOV, 16'd1);
        for (int j = 1; j <= 12; j++) begin
            tick_n(1);
            if (j == 4)  expect_v("rev_pos1", K_POS, 16'd1);
            if (j == 8)  expect_v("rev_pos2", K_POS, 16'd2);
            if (j == 10) begin
                expect_v("rev_flt_pre", K_FLT, 16'd1);
                direction = 1'b0;
            end
            if (j == 11) expect_v("rev_flt",  K_FLT, 16'd3);
            if (j == 11) expect_v("rev_hold", K_POS, 16'd2);
            if (j == 12) expect_v("rev_dec",  K_POS, 16'd1);
        end

        // Reset mid-motion
        tick_n(2);
        n_reset = 1'b0;
        #1;
        expect_v("mrst_pos",  K_POS,  16'd20);
        expect_v("mrst_flt",  K_FLT,  16'd0);
        expect_v("mrst_mov",  K_MOV,  16'd0);
        expect_v("mrst_sens", K_SENS, 16'b1001);
        tick_n(2);

        // 6: closed loop, stop on the top sensor
        n_reset   = 1'b1;
        enable    = 1'b0;
        direction = 1'b1;
        done      = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick_n(1);
            if (top == 1'b0) begin
                enable = 1'b1;
                done   = 1'b1;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL loop_timeout: top never asserted, position %0d expected 38", position);
        end
        tick_n(5);
        expect_v("loop_pos",  K_POS,  16'd38);
        expect_v("loop_sens", K_SENS, 16'b0111);
        expect_v("loop_flt",  K_FLT,  16'd0);
        expect_v("loop_mov",  K_MOV,  16'd0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) tick_n(1);
        total++;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
